// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller: state encoding,
// BCD digit constants and the mm:ss increment cascade.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } sw_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

  // One-second increment; 59:59 rolls over to 00:00.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != DIGIT_MAX) r.sec_ones = t.sec_ones + 4'd1;
    else begin
      r.sec_ones = '0;
      if (t.sec_tens != TENS_MAX) r.sec_tens = t.sec_tens + 4'd1;
      else begin
        r.sec_tens = '0;
        if (t.min_ones != DIGIT_MAX) r.min_ones = t.min_ones + 4'd1;
        else begin
          r.min_ones = '0;
          if (t.min_tens != TENS_MAX) r.min_tens = t.min_tens + 4'd1;
          else r.min_tens = '0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_press_edge.sv
// Rising-edge detector for a debounced button level: one pulse per press.
module press_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause and lap/clear buttons drive a 4-state FSM
// that sequences a tick-driven mm:ss BCD counter with a frozen lap display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               btn_start,
  input  logic               btn_lap,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [1:0]         state,
  output logic               running
);

  localparam int SUB_W = $clog2(TICKS_PER_SEC);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic       start_ev, lap_ev;
  sw_state_e  state_q;
  logic [SUB_W-1:0] sub_q;
  bcd_time_t  live_q, lap_q, disp;

  press_edge u_start (.clk(clk), .rst_n(rst_n), .level(btn_start), .pulse(start_ev));
  press_edge u_lap   (.clk(clk), .rst_n(rst_n), .level(btn_lap),   .pulse(lap_ev));

  // Counting decision uses the pre-edge state; FSM clears below override it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      running <= 1'b0;
      sub_q   <= '0;
      live_q  <= '0;
      lap_q   <= '0;
    end else begin
      if (tick && (state_q == S_RUN || state_q == S_LAP)) begin
        if (sub_q == SUB_LAST) begin
          sub_q  <= '0;
          live_q <= bcd_inc(live_q);
        end else begin
          sub_q <= sub_q + 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            state_q <= S_RUN;
            running <= 1'b1;
          end else if (lap_ev) begin
            live_q <= '0;
            sub_q  <= '0;
          end
        end
        S_RUN: begin
          if (start_ev) begin
            state_q <= S_PAUSE;
            running <= 1'b0;
          end else if (lap_ev) begin
            state_q <= S_LAP;
            lap_q   <= live_q;
          end
        end
        S_LAP: begin
          if (start_ev) begin
            state_q <= S_PAUSE;
            running <= 1'b0;
            lap_q   <= '0;
          end else if (lap_ev) begin
            state_q <= S_RUN;
          end
        end
        S_PAUSE: begin
          if (start_ev) begin
            state_q <= S_RUN;
            running <= 1'b1;
          end else if (lap_ev) begin
            state_q <= S_IDLE;
            live_q  <= '0;
            sub_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign disp     = (state_q == S_LAP) ? lap_q : live_q;
  assign min_tens = disp.min_tens;
  assign min_ones = disp.min_ones;
  assign sec_tens = disp.sec_tens;
  assign sec_ones = disp.sec_ones;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a queue scoreboard; a second
// instance at TICKS_PER_SEC=2 reaches the 59:59 rollover quickly.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, btn_start = 1'b0, btn_lap = 1'b0;
  logic tick2 = 1'b0, btn_start2 = 1'b0, btn_lap2 = 1'b0;
  logic [3:0] mt, mo, st, so, mt2, mo2, st2, so2;
  logic [1:0] state, state2;
  logic running, running2;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICKS_PER_SEC(100)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_start(btn_start), .btn_lap(btn_lap),
    .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
    .state(state), .running(running));

  stopwatch_ctrl #(.TICKS_PER_SEC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .btn_start(btn_start2), .btn_lap(btn_lap2),
    .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
    .state(state2), .running(running2));

  typedef struct {
    int         which;
    string      name;
    logic [15:0] disp;
    logic [1:0] st;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: pops every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [18:0] got, want;
      e = exp_q.pop_front();
      if (e.which == 0) got = {mt, mo, st, so, state, running};
      else              got = {mt2, mo2, st2, so2, state2, running2};
      want = {e.disp, e.st, e.run};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got disp=%h state=%0d run=%0d, expected disp=%h state=%0d run=%0d",
                 e.name, got[18:3], got[2:1], got[0], want[18:3], want[2:1], want[0]);
      end
    end
  end

  task automatic expect_out(input int which, input string name, input logic [15:0] disp,
                            input logic [1:0] s, input logic r);
    exp_t e;
    e.which = which; e.name = name; e.disp = disp; e.st = s; e.run = r;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1; cyc(n); tick = 1'b0;
  endtask

  task automatic ticks2(input int n);
    tick2 = 1'b1; cyc(n); tick2 = 1'b0;
  endtask

  task automatic press(input logic s, input logic l, input logic t);
    btn_start = s; btn_lap = l; tick = t;
    cyc(1);
    btn_start = 1'b0; btn_lap = 1'b0; tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(3);
    expect_out(0, "reset", 16'h0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // start, one second, held start gives a single pause event
    press(1, 0, 0);
    expect_out(0, "start_run", 16'h0000, 2'd1, 1'b1);
    ticks(100);
    expect_out(0, "one_sec", 16'h0001, 2'd1, 1'b1);
    btn_start = 1'b1; cyc(50);
    expect_out(0, "held_start", 16'h0001, 2'd2, 1'b0);
    btn_start = 1'b0; cyc(1);
    press(0, 1, 0);
    expect_out(0, "clear_idle", 16'h0000, 2'd0, 1'b0);

    // pause preserves the partial second; tick on resume cycle ignored
    press(1, 0, 0);
    ticks(340);
    press(1, 0, 0);
    expect_out(0, "pause_3s", 16'h0003, 2'd2, 1'b0);
    ticks(500);
    expect_out(0, "pause_hold", 16'h0003, 2'd2, 1'b0);
    press(1, 0, 1);
    ticks(60);
    expect_out(0, "resume_4s", 16'h0004, 2'd1, 1'b1);
    ticks(99);
    expect_out(0, "resume_tick_drop", 16'h0004, 2'd1, 1'b1);
    ticks(1);
    expect_out(0, "sub_zero", 16'h0005, 2'd1, 1'b1);

    // tick in the RUN->PAUSE cycle is counted
    ticks(99);
    press(1, 0, 1);
    expect_out(0, "pause_tick_counted", 16'h0006, 2'd2, 1'b0);
    press(1, 0, 0);
    ticks(100);
    expect_out(0, "run_7s", 16'h0007, 2'd1, 1'b1);

    // lap freeze and release
    press(0, 1, 0);
    expect_out(0, "lap_frozen", 16'h0007, 2'd3, 1'b1);
    ticks(300);
    expect_out(0, "lap_still", 16'h0007, 2'd3, 1'b1);
    press(0, 1, 0);
    expect_out(0, "lap_release", 16'h0010, 2'd1, 1'b1);
    ticks(99);
    press(0, 1, 1);
    expect_out(0, "lap_pre_tick", 16'h0010, 2'd3, 1'b1);
    press(1, 0, 0);
    expect_out(0, "lap_to_pause", 16'h0011, 2'd2, 1'b0);
    press(0, 1, 0);
    expect_out(0, "pause_clear", 16'h0000, 2'd0, 1'b0);

    // simultaneous start+lap: start wins, lap dropped
    press(1, 0, 0);
    ticks(200);
    press(1, 1, 0);
    expect_out(0, "simul_pause", 16'h0002, 2'd2, 1'b0);
    cyc(3);
    expect_out(0, "simul_no_queue", 16'h0002, 2'd2, 1'b0);
    press(0, 1, 0);
    expect_out(0, "simul_clear", 16'h0000, 2'd0, 1'b0);

    // rollover on the fast instance
    btn_start2 = 1'b1; cyc(1); btn_start2 = 1'b0; cyc(1);
    ticks2(1200);
    expect_out(1, "ten_min", 16'h1000, 2'd1, 1'b1);
    ticks2(5998);
    expect_out(1, "max_5959", 16'h5959, 2'd1, 1'b1);
    ticks2(1);
    expect_out(1, "max_partial", 16'h5959, 2'd1, 1'b1);
    ticks2(1);
    expect_out(1, "rollover", 16'h0000, 2'd1, 1'b1);

    // async reset mid-count while in LAP
    press(1, 0, 0);
    ticks(2500);
    press(0, 1, 0);
    expect_out(0, "lap_25", 16'h0025, 2'd3, 1'b1);
    cyc(1);
    #1 rst_n = 1'b0;
    expect_out(0, "async_reset", 16'h0000, 2'd0, 1'b0);
    btn_start = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    expect_out(0, "held_at_release", 16'h0000, 2'd1, 1'b1);
    btn_start = 1'b0;
    cyc(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven stopwatch controller for the board's 7-segment display path. It takes two debounced push-button levels and converts each to a single-cycle press event. A four-state FSM then sequences a 100 Hz tick-driven mm:ss BCD counter with start/pause, lap-freeze and clear. It sits between the debounce stage and the 7-segment scan driver, which consumes its four BCD digit outputs.

## Interface
- TICKS_PER_SEC, default 100: `tick` strobes per counted second; legal range 2..1023.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle timebase strobe (100 Hz nominal), synchronous to clk.
- btn_start  input  1  debounced level, start/pause button.
- btn_lap  input  1  debounced level, lap/clear button.
- min_tens  output  4  displayed minutes tens digit, BCD 0..5.
- min_ones  output  4  displayed minutes ones digit, BCD 0..9.
- sec_tens  output  4  displayed seconds tens digit, BCD 0..5.
- sec_ones  output  4  displayed seconds ones digit, BCD 0..9.
- state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- running  output  1  high in RUN or LAP.

## Operation
- Press detection per button:
  - A flop samples the level every clk.
  - The press event is `btn & ~btn_d` in the same cycle.
  - The FSM acts on the event at that cycle's posedge.
  - A held button yields exactly one event.
- FSM transitions (all other events are ignored):
  - IDLE: start → RUN. lap → IDLE, count cleared (no-op).
  - RUN: start → PAUSE. lap → LAP, live count copied into lap registers.
  - LAP: lap → RUN, display released. start → PAUSE, lap registers discarded and display shows live count.
  - PAUSE: start → RUN. lap → IDLE, live count and sub-second counter cleared to 0.
- Simultaneous start and lap events in one cycle: start wins; the lap event is dropped, not queued.
- Counting:
  - Active only in RUN and LAP.
  - Sub-second counter is 0..TICKS_PER_SEC-1, width clog2(TICKS_PER_SEC), and advances on `tick`.
  - At terminal count it wraps to 0 and the BCD seconds increment.
  - sec_ones 9→0 carries into sec_tens; 5→0 carries into min_ones, and so on.
  - 59:59 + 1s → 00:00 with no flag and no stop.
- PAUSE holds both the sub-second counter and the BCD count; resume continues the partial second.
- Display outputs: lap registers in LAP, live count otherwise. This is a mux driven by the state register only, so no glitch from inputs.

## Timing
- Reset: state=IDLE, running=0, all digits 0, sub-second counter 0, lap registers 0, button delay flops 0.
  - A button already held at reset release produces one event on the first cycle.
- Button-to-state latency: level high before posedge k gives the new state after edge k.
- Tick in a RUN→PAUSE or LAP→PAUSE cycle is counted (decision made on the old state).
- Tick in a PAUSE→RUN or IDLE→RUN cycle is not counted.
- Tick in a PAUSE→IDLE clear cycle is irrelevant; clear wins.
- Lap capture in the RUN→LAP cycle latches the count before that cycle's tick increment.
- Reset asserted mid-run returns everything to reset values immediately; no state survives.

## Structure
- Package `stopwatch_pkg`:
  - State encoding constants (IDLE/RUN/PAUSE/LAP).
  - BCD digit width 4.
  - Max digit constants 9 and 5.
- Sub-module `press_edge` (clk, rst_n, level in, pulse out, combinational pulse from registered delay) is instantiated twice.
- FSM, sub-second counter, BCD cascade and lap registers live in the top.

## Test plan
- Reset, start press, drive 100 ticks → sec_ones=1, state=RUN, running=1; hold btn_start 50 cycles → no second event.
- RUN, start at 3 s + 40 ticks, 500 ticks during PAUSE, start again, 60 ticks → display 00:04, sub-second counter 0.
- RUN at 00:07, lap → state=LAP, display frozen at 00:07 while 300 ticks advance the live count; lap → RUN, display 00:10.
- Preload 59:59 via 359 900 ticks at TICKS_PER_SEC=100, then one more second → 00:00, state stays RUN.
- Start and lap pressed in the same cycle from RUN → PAUSE only; then lap → IDLE, all digits 0.
- Deassert rst_n asynchronously mid-count at 00:25 in LAP → outputs 0 and state IDLE before the next posedge.
